// File: rtl/apbm_multi.sv
// APB master with a command FIFO, address decode onto NUM_SLV slave selects and one response per command.
// Define APBM_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT cycles without pready.
module apbm_multi #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int NUM_SLV   = 4,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                      pclk_i,
  input  logic                      prst_n,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [ADDR_W-1:0]         cmd_addr_i,
  input  logic [DATA_W-1:0]         cmd_wdata_i,
  output logic                      rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [NUM_SLV-1:0]        psel_o,
  output logic                      penable_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic                      pwrite_o,
  output logic [DATA_W-1:0]         pwdata_o,
  input  logic [NUM_SLV*DATA_W-1:0] prdata_i,
  input  logic [NUM_SLV-1:0]        pready_i,
  input  logic [NUM_SLV-1:0]        pslverr_i
);

  localparam int SEL_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int NUM_IDX = 1 << SEL_W;
  localparam int AW      = $clog2(CMD_DEPTH);
  localparam int PW      = AW + 1;
  localparam int CMD_W   = 1 + ADDR_W + DATA_W;
  localparam logic [SEL_W:0] IDX_LIM = (SEL_W + 1)'(NUM_SLV);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

`ifdef APBM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
`endif

  logic [CMD_W-1:0]    fifo_mem [CMD_DEPTH];
  logic                fifo_full, fifo_empty, push, pop, done;
  logic [CMD_W-1:0]    head;
  logic                head_write;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_wdata;
  logic [SEL_W-1:0]    head_idx;
  logic                head_derr;
  logic                apb_active;

  logic [DATA_W-1:0]   prdata_arr [NUM_IDX];
  logic [NUM_IDX-1:0]  pready_pad, pslverr_pad;

  // Pad per-slave inputs to a power of two so any idx_q value indexes safely.
  for (genvar gi = 0; gi < NUM_IDX; gi++) begin : g_pad
    if (gi < NUM_SLV) begin : g_real
      assign prdata_arr[gi]  = prdata_i[gi*DATA_W +: DATA_W];
      assign pready_pad[gi]  = pready_i[gi];
      assign pslverr_pad[gi] = pslverr_i[gi];
    end else begin : g_none
      assign prdata_arr[gi]  = '0;
      assign pready_pad[gi]  = 1'b0;
      assign pslverr_pad[gi] = 1'b0;
    end
  end

  assign apb_active = (state_q == SETUP) || (state_q == ACCESS);
  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_psel
    assign psel_o[gi] = apb_active && (idx_q == SEL_W'(gi));
  end

  assign penable_o   = (state_q == ACCESS);
  assign paddr_o     = cmd_addr_q;
  assign pwrite_o    = cmd_write_q;
  assign pwdata_o    = cmd_wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready_o = !fifo_full;
  assign push        = cmd_valid_i && !fifo_full;

  always_ff @(posedge pclk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= {cmd_write_i, cmd_addr_i, cmd_wdata_i};
    end
  end

  assign head       = fifo_mem[rd_ptr_q[AW-1:0]];
  assign head_write = head[CMD_W-1];
  assign head_addr  = head[DATA_W +: ADDR_W];
  assign head_wdata = head[DATA_W-1:0];
  assign head_idx   = head_addr[ADDR_W-1 -: SEL_W];
  assign head_derr  = ({1'b0, head_idx} >= IDX_LIM);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q + (push ? PW'(1) : PW'(0));
    rd_ptr_d    = rd_ptr_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    idx_d       = idx_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;
    done        = 1'b0;
`ifdef APBM_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        pop = !fifo_empty;
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef APBM_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (pready_pad[idx_q]) begin
          done        = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr_pad[idx_q];
          rsp_rdata_d = (cmd_write_q || pslverr_pad[idx_q]) ? '0 : prdata_arr[idx_q];
        end
`ifdef APBM_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          done        = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
      end
      DERR: begin
        done        = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase

    // A finishing transfer chains straight into the next queued command.
    if (done) begin
      state_d = IDLE;
      pop     = !fifo_empty;
    end

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      cmd_write_d = head_write;
      cmd_addr_d  = head_addr;
      cmd_wdata_d = head_wdata;
      idx_d       = head_idx;
      state_d     = head_derr ? DERR : SETUP;
    end
  end

  always_ff @(posedge pclk_i or negedge prst_n) begin
    if (!prst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APBM_TIMEOUT_EN
  always_ff @(posedge pclk_i or negedge prst_n) begin
    if (!prst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_apbm_multi.sv
// Directed bench for apbm_multi with three slaves: zero-wait write, wait states, back-to-back,
// decode error, PSLVERR, optional timeout and reset during a transfer.
module tb_apbm_multi;

  logic        pclk = 1'b0;
  logic        prst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [95:0] prdata;
  logic [2:0]  pready, pslverr;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  apbm_multi #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .CMD_DEPTH(4), .TIMEOUT(16)) dut (
    .pclk_i(pclk), .prst_n(prst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .psel_o(psel), .penable_o(penable), .paddr_o(paddr), .pwrite_o(pwrite), .pwdata_o(pwdata),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge pclk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    prst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    pready = 3'b111; pslverr = 3'b000;
    prdata = {32'h1234_5678, 32'hDEAD_0001, 32'h5555_AAAA};
    tick(); tick();
    vec_cnt++; if (cmd_ready !== 1'b1) begin miss_cnt++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
    vec_cnt++; if (rsp_valid !== 1'b0) begin miss_cnt++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    vec_cnt++; if (psel !== 3'b000) begin miss_cnt++; $display("FAIL rst_psel got=%b exp=000", psel); end
    vec_cnt++; if (penable !== 1'b0) begin miss_cnt++; $display("FAIL rst_penable got=%b exp=0", penable); end
    vec_cnt++; if (paddr !== 32'h0) begin miss_cnt++; $display("FAIL rst_paddr got=%h exp=0", paddr); end
    vec_cnt++; if ({pwrite, pwdata} !== 33'h0) begin miss_cnt++; $display("FAIL rst_pwrite_pwdata got=%b/%h exp=0/0", pwrite, pwdata); end
    vec_cnt++; if ({rsp_err, rsp_rdata} !== 33'h0) begin miss_cnt++; $display("FAIL rst_rsp got=%b/%h exp=0/0", rsp_err, rsp_rdata); end
    prst_n = 1'b1;
    tick();
    $display("reset: outputs checked");
  endtask

  task automatic test_write_zero_wait();
    pready = 3'b111;
    push_cmd(1'b1, 32'h0000_0010, 32'hA5A5_0001);
    vec_cnt++; if (psel !== 3'b000) begin miss_cnt++; $display("FAIL wr_idle_psel got=%b exp=000", psel); end
    tick();
    vec_cnt++; if (psel !== 3'b001 || penable !== 1'b0) begin miss_cnt++; $display("FAIL wr_setup got=%b/%b exp=001/0", psel, penable); end
    vec_cnt++; if (paddr !== 32'h0000_0010 || pwrite !== 1'b1 || pwdata !== 32'hA5A5_0001) begin miss_cnt++; $display("FAIL wr_setup_bus got=%h/%b/%h exp=00000010/1/a5a50001", paddr, pwrite, pwdata); end
    tick();
    vec_cnt++; if (psel !== 3'b001 || penable !== 1'b1 || rsp_valid !== 1'b0) begin miss_cnt++; $display("FAIL wr_access got=%b/%b/%b exp=001/1/0", psel, penable, rsp_valid); end
    tick();
    vec_cnt++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin miss_cnt++; $display("FAIL wr_rsp got=%b/%b/%h exp=1/0/00000000", rsp_valid, rsp_err, rsp_rdata); end
    vec_cnt++; if (psel !== 3'b000 || penable !== 1'b0) begin miss_cnt++; $display("FAIL wr_done_idle got=%b/%b exp=000/0", psel, penable); end
    tick();
    vec_cnt++; if (rsp_valid !== 1'b0) begin miss_cnt++; $display("FAIL wr_rsp_pulse got=%b exp=0", rsp_valid); end
    $display("write slv0 addr=00000010 data=a5a50001 done");
  endtask

  task automatic test_read_wait();
    pready = 3'b000;
    push_cmd(1'b0, 32'h8000_0004, 32'h0);
    tick();
    vec_cnt++; if (psel !== 3'b100 || penable !== 1'b0) begin miss_cnt++; $display("FAIL rd_setup got=%b/%b exp=100/0", psel, penable); end
    for (int i = 0; i < 4; i++) begin
      tick();
      vec_cnt++;
      if (psel !== 3'b100 || penable !== 1'b1 || paddr !== 32'h8000_0004 || pwrite !== 1'b0 || rsp_valid !== 1'b0) begin
        miss_cnt++;
        $display("FAIL rd_access_stable[%0d] got=%b/%b/%h/%b/%b exp=100/1/80000004/0/0", i, psel, penable, paddr, pwrite, rsp_valid);
      end
      if (i == 3) pready = 3'b111;
    end
    tick();
    vec_cnt++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h1234_5678) begin miss_cnt++; $display("FAIL rd_rsp got=%b/%b/%h exp=1/0/12345678", rsp_valid, rsp_err, rsp_rdata); end
    vec_cnt++; if (penable !== 1'b0 || psel !== 3'b000) begin miss_cnt++; $display("FAIL rd_done_idle got=%b/%b exp=000/0", psel, penable); end
    $display("read slv2 addr=80000004 3 waits rdata=%h", rsp_rdata);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_tab [5];
    logic        w_tab [5];
    logic [31:0] d_tab [5];
    logic [2:0]  s_tab [5];
    logic [31:0] r_tab [5];
    a_tab = '{32'h0000_0100, 32'h4000_0200, 32'h8000_0300, 32'h0000_0400, 32'h8000_0500};
    w_tab = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    d_tab = '{32'h0000_00A0, 32'h0, 32'h0000_00B0, 32'h0, 32'h0};
    s_tab = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b100};
    r_tab = '{32'h0, 32'hDEAD_0001, 32'h0, 32'h5555_AAAA, 32'h1234_5678};
    pready = 3'b000;
    for (int i = 0; i < 5; i++) begin
      vec_cnt++; if (cmd_ready !== 1'b1) begin miss_cnt++; $display("FAIL b2b_ready_before[%0d] got=%b exp=1", i, cmd_ready); end
      cmd_valid = 1'b1; cmd_write = w_tab[i]; cmd_addr = a_tab[i]; cmd_wdata = d_tab[i];
      tick();
    end
    cmd_valid = 1'b0;
    vec_cnt++; if (cmd_ready !== 1'b0) begin miss_cnt++; $display("FAIL b2b_full got=%b exp=0", cmd_ready); end
    vec_cnt++; if (psel !== s_tab[0] || penable !== 1'b1) begin miss_cnt++; $display("FAIL b2b_stall got=%b/%b exp=%b/1", psel, penable, s_tab[0]); end
    pready = 3'b111;
    for (int k = 0; k < 5; k++) begin
      tick();
      vec_cnt++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== r_tab[k]) begin
        miss_cnt++; $display("FAIL b2b_rsp[%0d] got=%b/%b/%h exp=1/0/%h", k, rsp_valid, rsp_err, rsp_rdata, r_tab[k]);
      end
      if (k < 4) begin
        vec_cnt++;
        if (psel !== s_tab[k+1] || penable !== 1'b0 || paddr !== a_tab[k+1] || pwrite !== w_tab[k+1]) begin
          miss_cnt++; $display("FAIL b2b_setup[%0d] got=%b/%b/%h/%b exp=%b/0/%h/%b", k+1, psel, penable, paddr, pwrite, s_tab[k+1], a_tab[k+1], w_tab[k+1]);
        end
        tick();
        vec_cnt++;
        if (psel !== s_tab[k+1] || penable !== 1'b1 || rsp_valid !== 1'b0) begin
          miss_cnt++; $display("FAIL b2b_access[%0d] got=%b/%b/%b exp=%b/1/0", k+1, psel, penable, rsp_valid, s_tab[k+1]);
        end
      end else begin
        vec_cnt++; if (psel !== 3'b000 || penable !== 1'b0) begin miss_cnt++; $display("FAIL b2b_final_idle got=%b/%b exp=000/0", psel, penable); end
      end
      $display("b2b cmd %0d addr=%h rsp rdata=%h err=%b", k, a_tab[k], rsp_rdata, rsp_err);
    end
    tick();
  endtask

  task automatic test_decode_err();
    push_cmd(1'b0, 32'hC000_0000, 32'h0);
    tick();
    vec_cnt++; if (psel !== 3'b000 || penable !== 1'b0 || rsp_valid !== 1'b0) begin miss_cnt++; $display("FAIL derr_state got=%b/%b/%b exp=000/0/0", psel, penable, rsp_valid); end
    tick();
    vec_cnt++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin miss_cnt++; $display("FAIL derr_rsp got=%b/%b/%h exp=1/1/00000000", rsp_valid, rsp_err, rsp_rdata); end
    vec_cnt++; if (psel !== 3'b000) begin miss_cnt++; $display("FAIL derr_psel got=%b exp=000", psel); end
    tick();
    vec_cnt++; if (rsp_valid !== 1'b0) begin miss_cnt++; $display("FAIL derr_pulse got=%b exp=0", rsp_valid); end
    $display("decode error addr=c0000000 err=1");
  endtask

  task automatic test_pslverr();
    prdata[63:32] = 32'hFFFF_FFFF;
    pslverr = 3'b010;
    push_cmd(1'b0, 32'h4000_0008, 32'h0);
    tick(); tick();
    vec_cnt++; if (psel !== 3'b010 || penable !== 1'b1) begin miss_cnt++; $display("FAIL slverr_access got=%b/%b exp=010/1", psel, penable); end
    tick();
    vec_cnt++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin miss_cnt++; $display("FAIL slverr_rsp got=%b/%b/%h exp=1/1/00000000", rsp_valid, rsp_err, rsp_rdata); end
    pslverr = 3'b000;
    prdata[63:32] = 32'hDEAD_0001;
    tick();
    $display("read slv1 pslverr err=1");
  endtask

`ifdef APBM_TIMEOUT_EN
  task automatic test_timeout();
    int acc;
    pready = 3'b000;
    push_cmd(1'b0, 32'h0000_0020, 32'h0);
    tick();
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (penable !== 1'b1) break;
      acc++;
    end
    vec_cnt++; if (acc != 16) begin miss_cnt++; $display("FAIL tmo_cycles got=%0d exp=16", acc); end
    vec_cnt++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin miss_cnt++; $display("FAIL tmo_rsp got=%b/%b/%h exp=1/1/00000000", rsp_valid, rsp_err, rsp_rdata); end
    pready = 3'b111;
    tick();
    $display("timeout abort after %0d access cycles", acc);
  endtask
`endif

  task automatic test_reset_mid();
    pready = 3'b000;
    push_cmd(1'b1, 32'h0000_0030, 32'h1111_1111);
    push_cmd(1'b0, 32'h4000_0034, 32'h0);
    push_cmd(1'b0, 32'h8000_0038, 32'h0);
    vec_cnt++; if (penable !== 1'b1 || psel !== 3'b001) begin miss_cnt++; $display("FAIL rstmid_pre got=%b/%b exp=001/1", psel, penable); end
    #2 prst_n = 1'b0;
    #1;
    vec_cnt++; if (psel !== 3'b000 || penable !== 1'b0) begin miss_cnt++; $display("FAIL rstmid_async got=%b/%b exp=000/0", psel, penable); end
    tick(); tick();
    prst_n = 1'b1;
    pready = 3'b111;
    for (int i = 0; i < 8; i++) begin
      tick();
      vec_cnt++;
      if (rsp_valid !== 1'b0 || psel !== 3'b000 || cmd_ready !== 1'b1) begin
        miss_cnt++; $display("FAIL rstmid_after[%0d] got=%b/%b/%b exp=0/000/1", i, rsp_valid, psel, cmd_ready);
      end
    end
    $display("reset during access: queue discarded");
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_back_to_back();
    test_decode_err();
    test_pslverr();
`ifdef APBM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/apbm_multi.md
# apbm_multi

Parametrised APB master, successor to the single-slave APB master. It accepts read/write commands through a valid/ready command port and buffers them in an internal command FIFO. It decodes each command's address onto one of NUM_SLV slave selects, runs the APB SETUP/ACCESS protocol with wait states and PSLVERR, and returns one response per command. It sits between a local request source and an APB slave fabric.

## Interface
- ADDR_W, 32, address width; must exceed SEL_W
- DATA_W, 32, data width (8/16/32)
- NUM_SLV, 4, number of slaves, 1..16; SEL_W = max(1, clog2(NUM_SLV))
- CMD_DEPTH, 4, command FIFO depth, power of two, >= 2
- TIMEOUT, 16, ACCESS-phase cycle limit (used only with APBM_TIMEOUT_EN)

Ports:
- pclk_i  in  1  clock, all logic on rising edge
- prst_n  in  1  reset; asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  = !fifo_full
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_W  byte address
- cmd_wdata_i  in  DATA_W  write data
- rsp_valid_o  out  1  one-cycle response strobe; no backpressure
- rsp_rdata_o  out  DATA_W  read data; 0 for writes and errors
- rsp_err_o  out  1  PSLVERR, decode error or timeout
- psel_o  out  NUM_SLV  one-hot slave select
- penable_o  out  1  APB enable
- paddr_o  out  ADDR_W  APB address
- pwrite_o  out  1  APB direction
- pwdata_o  out  DATA_W  APB write data
- prdata_i  in  NUM_SLV*DATA_W  slave s occupies bits [s*DATA_W +: DATA_W]
- pready_i  in  NUM_SLV  per-slave ready
- pslverr_i  in  NUM_SLV  per-slave error

## Operation
- FIFO: a push occurs when cmd_valid_i && cmd_ready_o; there is no bypass, so a pushed entry is visible the cycle after. Push and pop in the same cycle are allowed when not full. Pointers wrap modulo CMD_DEPTH; the extra pointer bit distinguishes full from empty.
- Decode: idx = addr[ADDR_W-1 -: SEL_W]. idx >= NUM_SLV is a decode error.
- FSM states: IDLE, SETUP, ACCESS, DERR.
  - IDLE, FIFO non-empty: pop the head into the command register. Go to SETUP, or to DERR on a decode error.
  - SETUP: psel_o[idx]=1, penable_o=0. Go unconditionally to ACCESS.
  - ACCESS: psel_o[idx]=1, penable_o=1. If pready_i[idx]=1, the transfer completes:
    - capture prdata/pslverr of slave idx into the response;
    - if the FIFO is non-empty, pop and go to SETUP/DERR (back-to-back, no IDLE cycle); otherwise go to IDLE.
    - If pready_i[idx]=0, stay in ACCESS with all APB outputs stable.
  - DERR: no psel_o bit is asserted. Issue the response with err=1, rdata=0. Next state as for ACCESS completion.
- paddr_o/pwrite_o/pwdata_o are driven from the command register and hold their last value in IDLE.
- Only psel_o[idx] is ever high; psel_o is all-zero in IDLE and DERR.
- rsp_rdata_o = captured prdata for reads; 0 for writes and for any error.

## Timing
- Reset values: cmd_ready_o=1; every other output is 0; FIFO empty; state IDLE.
- Reset asserted mid-transfer: psel_o/penable_o fall asynchronously. In-flight and queued commands are discarded with no response.
- Zero-wait latency: command accepted at edge N with the FIFO empty and FSM in IDLE:
  - SETUP after edge N+1;
  - ACCESS after edge N+2;
  - completion at edge N+3;
  - rsp_valid_o high for the cycle following edge N+3.
- Each wait state adds one cycle.
- Back-to-back throughput: one transfer per 2 cycles. rsp_valid_o pulses may be separated by one low cycle.
- Decode-error latency: rsp_valid_o is high for the cycle after the edge that leaves DERR, i.e. 2 edges after the pop.
- rsp_valid_o is never high for two consecutive cycles.

## Configuration
- APBM_TIMEOUT_EN defined: a counter clears on entry to ACCESS and increments each ACCESS cycle without pready. On reaching TIMEOUT, the transfer aborts:
  - psel/penable drop;
  - the response has err=1, rdata=0;
  - next state as for a normal completion.
- APBM_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely. The TIMEOUT parameter is unused.

## Test plan
- Reset, then one write (addr 0x0000_0010, data 0xA5A5_0001) to slave 0 with pready tied high:
  - psel_o=4'b0001 for 2 cycles, penable on the second;
  - rsp_valid_o 3 cycles after acceptance with err=0, rdata=0.
- Read from slave 2 (addr 0x8000_0004), 3 wait states, prdata slice 2 = 0x1234_5678:
  - response rdata=0x1234_5678, err=0;
  - APB outputs stable throughout ACCESS.
- Push 5 commands back-to-back with CMD_DEPTH=4 while the slave stalls:
  - cmd_ready_o low after 4 accepted (5th if one already popped);
  - all complete in order, no IDLE between transfers.
- NUM_SLV=3, addr 0xC000_0000:
  - psel_o stays 0;
  - response err=1, rdata=0, two edges after the pop.
- pslverr_i[1]=1 on a read returning 0xFFFF_FFFF: response err=1, rdata=0. With APBM_TIMEOUT_EN and TIMEOUT=16, pready held low: abort after 16 ACCESS cycles with err=1.
- Assert prst_n low during ACCESS with 2 commands queued:
  - psel/penable drop immediately;
  - no response after release;
  - cmd_ready_o=1.
